// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding CPU-to-RAM controller.
// A request is taken only in IDLE. A read pulses readMem for one cycle and then waits
// for memDataReady, giving up after TIMEOUT cycles. A write pulses wren for one cycle.
// Every operation ends with a single RESP cycle, in which cpu_done is 1.
//
// Handshake: cpu_req is a valid strobe. The block is ready to take it only while
// cpu_busy=0. A request seen while busy is dropped: it is not queued and has no side
// effect. cpu_rdata and cpu_err are valid only while cpu_done=1.
// All outputs come straight from flops. Each one is computed from the next state, so it
// lines up with the state register.
module mem_ctrl #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_busy,
    output logic        readMem,
    output logic [15:0] address,
    output logic [15:0] data,
    output logic        wren,
    input  logic [15:0] mem_q,
    input  logic        memDataReady,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR       = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] address_n, data_n, rdata_n;
    logic        err_n;

    assign dbg_state = state;

    // Next-state logic, timeout counting and the next values of the data registers.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        address_n = address;
        data_n    = data;
        rdata_n   = cpu_rdata;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    address_n = cpu_addr;
                    if (cpu_we) begin
                        data_n  = cpu_wdata;
                        state_n = WR;
                    end else begin
                        state_n = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                state_n = RD_WAIT;
                cnt_n   = 8'd1;
            end
            RD_WAIT: begin
                // If data and the timeout arrive in the same cycle, the data is used.
                if (memDataReady) begin
                    rdata_n = mem_q;
                    state_n = RESP;
                end else if (cnt == 8'(TIMEOUT)) begin
                    rdata_n = 16'h0000;
                    err_n   = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            WR: begin
                state_n = RESP;
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // State register plus the registered outputs. Reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            address   <= 16'h0000;
            data      <= 16'h0000;
            cpu_rdata <= 16'h0000;
            cpu_err   <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_busy  <= 1'b0;
            readMem   <= 1'b0;
            wren      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            address   <= address_n;
            data      <= data_n;
            cpu_rdata <= rdata_n;
            cpu_err   <= err_n;
            cpu_done  <= (state_n == RESP);
            cpu_busy  <= (state_n != IDLE);
            readMem   <= (state_n == RD_ISSUE);
            wren      <= (state_n == WR);
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed test of mem_ctrl with a behavioural single-cycle RAM.
// Inputs are driven, and outputs sampled, 1 time unit after each rising clock edge.
module tb_mem_ctrl;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
    logic [15:0] cpu_rdata, address, data, mem_q;
    logic        cpu_done, cpu_err, cpu_busy, readMem, wren, memDataReady;
    logic [2:0]  dbg_state;

    mem_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
        .readMem(readMem), .address(address), .data(data), .wren(wren),
        .mem_q(mem_q), .memDataReady(memDataReady), .dbg_state(dbg_state)
    );

    // RAM model. ram_mode selects the read response:
    //   0 = normal RAM, ready one cycle after readMem
    //   1 = silent, memDataReady held at 0
    //   2 = memDataReady and mem_q driven by hand from the bench
    logic [15:0] ram [0:65535];
    logic [15:0] ram_q = 16'h0;
    logic        ram_rdy = 1'b0;
    logic [1:0]  ram_mode = 2'd0;
    logic        man_rdy = 1'b0;
    logic [15:0] man_q = 16'h0;
    int          rd_pulses = 0;

    always @(posedge clk) begin
        ram_rdy <= readMem;
        if (readMem) begin
            ram_q     <= ram[address];
            rd_pulses <= rd_pulses + 1;
        end
        if (wren) ram[address] <= data;
    end

    assign memDataReady = (ram_mode == 2'd0) ? ram_rdy : (ram_mode == 2'd2) ? man_rdy : 1'b0;
    assign mem_q        = (ram_mode == 2'd2) ? man_q : ram_q;

    // Scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        tick();
        cpu_req   = 1'b0;
    endtask

    int cycles;

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0;
        ram[16'h0001] = 16'h1111;
        ram[16'h0002] = 16'h2222;
        ram[16'hFFFF] = 16'h0A0A;

        // Reset state
        tick(); tick();
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_outs", {cpu_done, cpu_err, cpu_busy, readMem, wren}, 32'd0);
        check("rst_addr", address, 32'h0);
        check("rst_data", data, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Write 0x0010 <= 0xBEEF. wren in cycle N+1, cpu_done in cycle N+2.
        issue(1'b1, 16'h0010, 16'hBEEF);
        check("wr_wren", wren, 32'd1);
        check("wr_data", data, 32'hBEEF);
        check("wr_addr", address, 32'h0010);
        check("wr_busy", cpu_busy, 32'd1);
        check("wr_nodone", cpu_done, 32'd0);
        check("wr_nord", readMem, 32'd0);
        tick();
        check("wr_wren_off", wren, 32'd0);
        check("wr_done", cpu_done, 32'd1);
        check("wr_err", cpu_err, 32'd0);
        tick();
        check("wr_done_off", cpu_done, 32'd0);
        check("wr_idle", cpu_busy, 32'd0);
        check("wr_ram", ram[16'h0010], 32'hBEEF);

        // Read back 0x0010. readMem in cycle N+1, cpu_done in cycle N+3.
        issue(1'b0, 16'h0010, 16'h0);
        check("rd_readmem", readMem, 32'd1);
        check("rd_addr", address, 32'h0010);
        tick();
        check("rd_readmem_off", readMem, 32'd0);
        check("rd_nodone", cpu_done, 32'd0);
        tick();
        check("rd_done", cpu_done, 32'd1);
        check("rd_rdata", cpu_rdata, 32'hBEEF);
        check("rd_err", cpu_err, 32'd0);
        tick();
        check("rd_done_off", cpu_done, 32'd0);

        // cpu_req held high through a read of 0x0001 while cpu_addr moves to 0x0002.
        rd_pulses = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
        tick();
        cpu_addr = 16'h0002;
        tick();
        check("bsy_addr_hold", address, 32'h0001);
        tick();
        check("bsy_done", cpu_done, 32'd1);
        check("bsy_rdata", cpu_rdata, 32'h1111);
        tick();
        check("bsy_idle", cpu_busy, 32'd0);
        check("bsy_addr_idle", address, 32'h0001);
        check("bsy_one_read", rd_pulses, 32'd1);
        tick();
        cpu_req = 1'b0;
        check("bsy_next_accept", readMem, 32'd1);
        check("bsy_next_addr", address, 32'h0002);
        tick(); tick();
        check("bsy_next_rdata", cpu_rdata, 32'h2222);
        check("bsy_next_done", cpu_done, 32'd1);
        tick();

        // Timeout with the RAM silent. cpu_done comes 9 cycles after the readMem pulse.
        ram_mode = 2'd1;
        issue(1'b0, 16'h0100, 16'h0);
        check("to_readmem", readMem, 32'd1);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!cpu_done && cycles < 20);
        check("to_latency", cycles, 32'd9);
        check("to_err", cpu_err, 32'd1);
        check("to_rdata", cpu_rdata, 32'h0);
        tick();
        check("to_err_off", cpu_err, 32'd0);

        // memDataReady while IDLE has no effect.
        ram_mode = 2'd2;
        man_rdy = 1'b1; man_q = 16'h7777;
        tick();
        man_rdy = 1'b0;
        tick();
        check("ign_rdy_busy", cpu_busy, 32'd0);
        check("ign_rdy_rdata", cpu_rdata, 32'h0);

        // Tie: data first arrives on the 8th RD_WAIT cycle.
        issue(1'b0, 16'h0200, 16'h0);
        for (int j = 0; j < 8; j++) tick();
        check("tie_nodone", cpu_done, 32'd0);
        man_rdy = 1'b1; man_q = 16'h1234;
        tick();
        man_rdy = 1'b0;
        check("tie_done", cpu_done, 32'd1);
        check("tie_err", cpu_err, 32'd0);
        check("tie_rdata", cpu_rdata, 32'h1234);
        tick();
        ram_mode = 2'd0;

        // Reset asserted during the WR cycle.
        issue(1'b1, 16'h0020, 16'h5555);
        check("rw_wren", wren, 32'd1);
        rst = 1'b1;
        tick();
        check("rw_wren_off", wren, 32'd0);
        check("rw_nodone", cpu_done, 32'd0);
        check("rw_busy", cpu_busy, 32'd0);
        check("rw_addr", address, 32'h0);
        // While rst=1, cpu_req must not be accepted.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0003;
        tick();
        check("rst_prio", cpu_busy, 32'd0);
        cpu_req = 1'b0;
        rst = 1'b0;
        tick();
        check("rw_after_done", cpu_done, 32'd0);
        check("rw_after_busy", cpu_busy, 32'd0);

        // Boundary address 0xFFFF.
        issue(1'b0, 16'hFFFF, 16'h0);
        check("ff_addr", address, 32'hFFFF);
        tick(); tick();
        check("ff_done", cpu_done, 32'd1);
        check("ff_rdata", cpu_rdata, 32'h0A0A);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8, meaning max cycles spent in RD_WAIT before error (legal range 1..255).
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have the port cpu_req, input, 1 bit, a request strobe, sampled only while cpu_busy=0.
REQ-005 The block SHALL have the port cpu_we, input, 1 bit, where 1=write and 0=read, sampled with cpu_req.
REQ-006 The block SHALL have the port cpu_addr, input, 16 bits, the word address.
REQ-007 The block SHALL have the port cpu_wdata, input, 16 bits, the write data.
REQ-008 The block SHALL have the port cpu_rdata, output, 16 bits, the read result, valid while cpu_done=1.
REQ-009 The block SHALL have the port cpu_done, output, 1 bit, a one-cycle completion pulse.
REQ-010 The block SHALL have the port cpu_err, output, 1 bit, a read-timeout flag, valid with cpu_done.
REQ-011 The block SHALL have the port cpu_busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-012 The block SHALL have the port readMem, output, 1 bit, the read strobe to RAM.
REQ-013 The block SHALL have the port address, output, 16 bits, the RAM address.
REQ-014 The block SHALL have the port data, output, 16 bits, the RAM write data.
REQ-015 The block SHALL have the port wren, output, 1 bit, the RAM write enable.
REQ-016 The block SHALL have the port mem_q, input, 16 bits, the RAM read data (connects to RAM out).
REQ-017 The block SHALL have the port memDataReady, input, 1 bit, the RAM read-ready, asserted by RAM the cycle after it samples readMem=1.

Function
REQ-018 The FSM SHALL have the states IDLE, RD_ISSUE, RD_WAIT, WR, RESP; all outputs registered.
REQ-019 In IDLE with cpu_req=1, the block SHALL latch cpu_we/cpu_addr/cpu_wdata into holding registers and move to WR (we=1) or RD_ISSUE (we=0).
REQ-020 A cpu_req while cpu_busy=1 SHALL be ignored (not queued, no side effect).
REQ-021 address SHALL equal the latched address from the cycle after acceptance until leaving RESP, and SHALL hold its last value in IDLE.
REQ-022 RD_ISSUE SHALL last exactly one cycle with readMem=1, then go to RD_WAIT; readMem SHALL be 0 in every other state.
REQ-023 In RD_WAIT with memDataReady=1, the block SHALL capture mem_q into cpu_rdata, set cpu_err=0, and go to RESP.
REQ-024 RD_WAIT SHALL count cycles from 1; if the count reaches TIMEOUT with memDataReady=0, the block SHALL set cpu_rdata=16'h0000 and cpu_err=1, and go to RESP.
REQ-025 If memDataReady=1 in the same cycle the count reaches TIMEOUT, data SHALL win (cpu_err=0).
REQ-026 memDataReady seen outside RD_WAIT SHALL be ignored.
REQ-027 WR SHALL last exactly one cycle with wren=1 and data=latched wdata, then go to RESP; wren SHALL be 0 in every other state.
REQ-028 For a write, cpu_rdata SHALL be unchanged and cpu_err SHALL be 0.
REQ-029 RESP SHALL last exactly one cycle with cpu_done=1, then go to IDLE; cpu_done SHALL be 0 elsewhere.
REQ-030 Read latency SHALL be: acceptance edge N, readMem high in cycle N+1, capture at edge N+2, cpu_done high in cycle N+3 (memDataReady arriving one cycle after readMem).
REQ-031 Write latency SHALL be: acceptance edge N, wren high in cycle N+1, cpu_done high in cycle N+2.
REQ-032 A new request SHALL be accepted no earlier than the first IDLE cycle after RESP (back-to-back throughput: 4 cycles per read, 3 cycles per write).
REQ-033 Address and data SHALL pass through unmodified at 16 bits with no wrap or arithmetic; 16'hFFFF SHALL be legal.

Reset
REQ-034 When rst=1 at a clock edge, the FSM SHALL go to IDLE and the timeout counter SHALL clear.
REQ-035 When rst=1 at a clock edge, readMem, wren, cpu_done, cpu_err and cpu_busy SHALL be 0, and address, data and cpu_rdata SHALL be 16'h0000.
REQ-036 Reset during WR or RD_* SHALL abort the operation with no cpu_done pulse.
REQ-037 Reset during WR SHALL drop wren at that same edge.
REQ-038 rst SHALL take priority over cpu_req in the same cycle.

Verification
REQ-039 The bench SHALL cover write then read: write addr 16'h0010 data 16'hBEEF, then read 16'h0010; the response SHALL be wren pulse 1 cycle, done 2 cycles after accept, read done 3 cycles after accept, cpu_rdata=16'hBEEF, cpu_err=0.
REQ-040 The bench SHALL cover a busy-ignore case: cpu_req held high through a read to 16'h0001 with cpu_addr changing to 16'h0002 mid-op; the response SHALL be only 16'h0001 accessed, and the next accept on the first IDLE cycle.
REQ-041 The bench SHALL cover a timeout: memDataReady tied 0, TIMEOUT=8; the response SHALL be cpu_done with cpu_err=1 and cpu_rdata=16'h0000, 9 cycles after the readMem pulse.
REQ-042 The bench SHALL cover a timeout tie: memDataReady first asserted on the TIMEOUT-th RD_WAIT cycle with mem_q=16'h1234; the response SHALL be cpu_err=0 and cpu_rdata=16'h1234.
REQ-043 The bench SHALL cover reset mid-write: rst asserted during the WR cycle; the response SHALL be wren=0 next cycle, no cpu_done, and cpu_busy=0.
REQ-044 The bench SHALL cover the boundary address: read from 16'hFFFF preloaded with 16'h0A0A; the response SHALL be address=16'hFFFF and cpu_rdata=16'h0A0A.
